// File: rtl/tag_ram_pkg.sv
// Shared types and helpers for the set-associative tag store.
package tag_ram_pkg;

  typedef enum logic [0:0] {
    FLUSH = 1'b0,
    READY = 1'b1
  } state_e;

  // Way-index width. A single way still gets one bit so that ports never collapse to zero width.
  function automatic int way_width(input int ways);
    if (ways <= 2) begin
      return 1;
    end else begin
      return $clog2(ways);
    end
  endfunction

endpackage

// File: rtl/tag_way_bank.sv
// One way of the tag store: a tag array, a per-set valid vector, and a registered compare
// whose result is held until the next lookup or response clear.
module tag_way_bank #(
  parameter int IDX_W = 3,
  parameter int TAG_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_index,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [TAG_W-1:0] rd_tag,
  output logic             match_q,
  output logic             valid_q
);

  localparam int DEPTH = 1 << IDX_W;

  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [DEPTH-1:0] valid_vec_q;
  logic [DEPTH-1:0] valid_vec_d;
  logic             match_d;
  logic             valid_d;

  // Valid-bit update: flush clears take priority (fills never happen while flushing).
  always_comb begin
    valid_vec_d = valid_vec_q;
    if (clr_en) begin
      valid_vec_d[clr_index] = 1'b0;
    end else if (wr_en) begin
      valid_vec_d[wr_index] = 1'b1;
    end else begin
      valid_vec_d = valid_vec_q;
    end
  end

  // The compare reads the pre-write contents, which makes a same-cycle fill read-first.
  always_comb begin
    match_d = match_q;
    valid_d = valid_q;
    if (rd_en) begin
      valid_d = valid_vec_q[rd_index];
      match_d = valid_vec_q[rd_index] & (tag_mem_q[rd_index] == rd_tag);
    end else if (rd_clr) begin
      valid_d = 1'b0;
      match_d = 1'b0;
    end else begin
      valid_d = valid_q;
      match_d = match_q;
    end
  end

  // Tag contents are intentionally left unreset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem_q[wr_index] <= wr_tag;
    end
  end

  // Valid vector and compare result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_vec_q <= {DEPTH{1'b0}};
      match_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_vec_q <= valid_vec_d;
      match_q     <= match_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: rtl/tag_ram_assoc.sv
// N-way set-associative tag store with hit/way reporting, victim suggestion
// (first invalid way, else per-set round-robin) and a self-timed flush.
module tag_ram_assoc
  import tag_ram_pkg::*;
#(
  parameter  int IDX_W = 3,
  parameter  int TAG_W = 7,
  parameter  int WAYS  = 2,
  localparam int WAY_W = way_width(WAYS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lookup_valid,
  output logic             lookup_ready,
  input  logic [IDX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             flush_req,
  output logic             flush_busy
);

  localparam int               DEPTH  = 1 << IDX_W;
  localparam logic [WAY_W:0]   WAYS_L = (WAY_W+1)'(WAYS);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WAY_W-1:0] rsp_ptr_q, rsp_ptr_d;
  logic [WAY_W-1:0] rr_ptr_q [DEPTH];
  logic [WAY_W-1:0] rr_ptr_d [DEPTH];

  logic             lookup_fire;
  logic             fill_fire;
  logic             rsp_clr;
  logic [WAY_W:0]   way_inc;
  logic [WAY_W-1:0] next_ptr;
  logic [WAYS-1:0]  match_vec;
  logic [WAYS-1:0]  valid_vec;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] inv_way;
  logic             inv_found;
  logic             any_hit;

  assign lookup_fire = lookup_valid & ready_q;
  assign fill_fire   = fill_valid & ready_q & ({1'b0, fill_way} < WAYS_L);

  // Flush sequencer: one set per cycle, then back to READY.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      FLUSH: begin
        if (flush_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d     = READY;
          flush_cnt_d = {IDX_W{1'b0}};
        end else begin
          flush_cnt_d = flush_cnt_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      READY: begin
        if (flush_req) begin
          state_d     = FLUSH;
          flush_cnt_d = {IDX_W{1'b0}};
        end else begin
          state_d     = READY;
        end
      end
      default: begin
        state_d     = FLUSH;
        flush_cnt_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // A response accepted on the flush-request edge still goes out; otherwise entering or
  // staying in FLUSH zeroes the response fields.
  assign rsp_clr = (state_d == FLUSH);

  // Round-robin pointer advance: (fill_way + 1) mod WAYS.
  always_comb begin
    way_inc = {1'b0, fill_way} + {{WAY_W{1'b0}}, 1'b1};
    if (way_inc == WAYS_L) begin
      next_ptr = {WAY_W{1'b0}};
    end else begin
      next_ptr = way_inc[WAY_W-1:0];
    end
  end

  // Response bookkeeping and pointer table updates.
  always_comb begin
    ready_d     = (state_d == READY);
    rsp_valid_d = lookup_fire;
    rsp_ptr_d   = rsp_ptr_q;
    rr_ptr_d    = rr_ptr_q;
    if (lookup_fire) begin
      rsp_ptr_d = rr_ptr_q[lookup_index];
    end else if (rsp_clr) begin
      rsp_ptr_d = {WAY_W{1'b0}};
    end else begin
      rsp_ptr_d = rsp_ptr_q;
    end
    if (state_q == FLUSH) begin
      rr_ptr_d[flush_cnt_q] = {WAY_W{1'b0}};
    end else if (fill_fire) begin
      rr_ptr_d[fill_index] = next_ptr;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FLUSH;
      flush_cnt_q <= {IDX_W{1'b0}};
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_ptr_q   <= {WAY_W{1'b0}};
      for (int s = 0; s < DEPTH; s++) begin
        rr_ptr_q[s] <= {WAY_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ptr_q   <= rsp_ptr_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    tag_way_bank #(
      .IDX_W(IDX_W),
      .TAG_W(TAG_W)
    ) u_bank (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (fill_fire & (fill_way == WAY_W'(w))),
      .wr_index (fill_index),
      .wr_tag   (fill_tag),
      .clr_en   (state_q == FLUSH),
      .clr_index(flush_cnt_q),
      .rd_en    (lookup_fire),
      .rd_clr   (rsp_clr),
      .rd_index (lookup_index),
      .rd_tag   (lookup_tag),
      .match_q  (match_vec[w]),
      .valid_q  (valid_vec[w])
    );
  end

  // Lowest matching way, lowest invalid way, then the pointer captured at lookup time.
  always_comb begin
    hit_way   = {WAY_W{1'b0}};
    inv_way   = {WAY_W{1'b0}};
    inv_found = 1'b0;
    any_hit   = |match_vec;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match_vec[w]) begin
        hit_way = WAY_W'(w);
      end else begin
        hit_way = hit_way;
      end
      if (!valid_vec[w]) begin
        inv_way   = WAY_W'(w);
        inv_found = 1'b1;
      end else begin
        inv_way   = inv_way;
      end
    end
    if (any_hit) begin
      rsp_way = hit_way;
    end else if (inv_found) begin
      rsp_way = inv_way;
    end else begin
      rsp_way = rsp_ptr_q;
    end
  end

  assign rsp_hit      = any_hit;
  assign rsp_valid    = rsp_valid_q;
  assign lookup_ready = ready_q;
  assign flush_busy   = ~ready_q;

endmodule

// File: tb/tb_tag_ram_assoc.sv
// Scoreboard bench for tag_ram_assoc: directed scenarios plus random traffic against an
// array-based reference model of sets, ways, valid bits and round-robin pointers.
module tb_tag_ram_assoc;

  localparam int IDX_W = 3;
  localparam int TAG_W = 7;
  localparam int WAYS  = 2;
  localparam int DEPTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             lookup_valid;
  logic             lookup_ready;
  logic [IDX_W-1:0] lookup_index;
  logic [TAG_W-1:0] lookup_tag;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [0:0]       rsp_way;
  logic             fill_valid;
  logic [IDX_W-1:0] fill_index;
  logic [0:0]       fill_way;
  logic [TAG_W-1:0] fill_tag;
  logic             flush_req;
  logic             flush_busy;

  tag_ram_assoc #(.IDX_W(IDX_W), .TAG_W(TAG_W), .WAYS(WAYS)) dut (
    .clock(clock), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_index(lookup_index), .lookup_tag(lookup_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way), .fill_tag(fill_tag),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  always #5 clock = ~clock;

  // Reference model
  bit m_valid [DEPTH][WAYS];
  int m_tag   [DEPTH][WAYS];
  int m_ptr   [DEPTH];
  bit m_ready = 1'b0;
  int m_left  = DEPTH;
  int exp_hit [$];
  int exp_way [$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic clear_model();
    for (int s = 0; s < DEPTH; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  // Applies one clock edge's worth of behaviour to the model, using the inputs just sampled.
  task automatic model_edge();
    int s, h, w, inv;
    if (reset) begin
      clear_model();
      m_ready = 1'b0;
      m_left  = DEPTH;
    end else if (m_ready) begin
      if (lookup_valid) begin
        s = int'(lookup_index);
        h = 0; w = 0; inv = 0;
        for (int k = 0; k < WAYS; k++)
          if (h == 0 && m_valid[s][k] && m_tag[s][k] == int'(lookup_tag)) begin h = 1; w = k; end
        if (h == 0) begin
          for (int k = 0; k < WAYS; k++)
            if (inv == 0 && !m_valid[s][k]) begin inv = 1; w = k; end
          if (inv == 0) w = m_ptr[s];
        end
        exp_hit.push_back(h);
        exp_way.push_back(w);
      end
      if (fill_valid && int'(fill_way) < WAYS) begin
        s = int'(fill_index);
        m_tag[s][int'(fill_way)]   = int'(fill_tag);
        m_valid[s][int'(fill_way)] = 1'b1;
        m_ptr[s] = (int'(fill_way) + 1) % WAYS;
      end
      if (flush_req) begin
        m_ready = 1'b0;
        m_left  = DEPTH;
        clear_model();
      end
    end else begin
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end
  endtask

  task automatic cyc(input bit rst, input bit lv, input int li, input int lt,
                     input bit fv, input int fi, input int fw, input int ft, input bit fr);
    reset        = rst;
    lookup_valid = lv;
    lookup_index = IDX_W'(li);
    lookup_tag   = TAG_W'(lt);
    fill_valid   = fv;
    fill_index   = IDX_W'(fi);
    fill_way     = 1'(fw);
    fill_tag     = TAG_W'(ft);
    flush_req    = fr;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(input int li, input int lt);
    cyc(0, 1, li, lt, 0, 0, 0, 0, 0);
  endtask

  task automatic fill(input int fi, input int fw, input int ft);
    cyc(0, 0, 0, 0, 1, fi, fw, ft, 0);
  endtask

  // Monitor: every response must appear exactly one cycle after its lookup was accepted.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("lookup_ready", int'(lookup_ready), int'(m_ready));
      chk("flush_busy", int'(flush_busy), int'(!m_ready));
      if (exp_hit.size() > 0) begin
        int eh, ew;
        eh = exp_hit.pop_front();
        ew = exp_way.pop_front();
        chk("rsp_valid", int'(rsp_valid), 1);
        if (rsp_valid) begin
          chk("rsp_hit", int'(rsp_hit), eh);
          chk("rsp_way", int'(rsp_way), ew);
        end
      end else begin
        chk("no_rsp", int'(rsp_valid), 0);
        if (flush_busy) begin
          chk("flush_hit_zero", int'(rsp_hit), 0);
          chk("flush_way_zero", int'(rsp_way), 0);
        end
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(DEPTH);
    lookup(5, 'h2A);

    fill(5, 0, 'h2A);
    lookup(5, 'h2A);
    lookup(5, 'h11);

    fill(3, 0, 'h10);
    fill(3, 1, 'h20);
    lookup(3, 'h30);
    fill(3, 0, 'h31);
    lookup(3, 'h32);

    cyc(0, 1, 2, 'h7F, 1, 2, 0, 'h7F, 0);
    lookup(2, 'h7F);

    for (int s = 0; s < DEPTH; s++) fill(s, s % 2, 'h50 + s);
    lookup(6, 'h56);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 6, 'h56, 1, 1, 0, 'h01, 0);
    cyc(0, 1, 1, 'h51, 1, 1, 0, 'h01, 1);
    idle(DEPTH);
    for (int s = 0; s < DEPTH; s++) lookup(s, 'h50 + s);

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(DEPTH + 1);
    fill(4, 1, 'h44);
    for (int i = 0; i < 4; i++) lookup(4, 'h44 - i);

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 149) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1), $urandom_range(0, 3),
          $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1), $urandom_range(0, 1),
          $urandom_range(0, 3),
          $urandom_range(0, 39) == 0);
    end

    idle(3);
    chk("scoreboard_drained", exp_hit.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
